// File: rtl/pwm_gen.sv
// pwm_gen: counter-based PWM generator with double-buffered period/duty.
//
// A new period/duty written with `load` is held pending and only takes
// effect at the next period wrap, so a running period is never cut short
// or stretched. While `en` is low the output is parked at 0 and any
// pending values are applied at once, so the first tick after `en` rises
// wraps and starts a clean period.
//
// Build option: define PWM_TICK_SYNC_EN when `tick` is a free-running
// level clock from a divider. It is then passed through a 2-flop
// synchronizer and edge-detected into a one-clk count pulse. Without the
// macro, `tick` is already a one-clk enable pulse and is used directly.
//
// Ports:
//   clk        in   system clock, all state on posedge
//   reset      in   asynchronous active-low reset
//   en         in   run enable
//   tick       in   count enable (pulse, or level clock with PWM_TICK_SYNC_EN)
//   load       in   capture period/duty into the pending registers
//   period     in   [WIDTH] PWM period minus one, in ticks
//   duty       in   [WIDTH] high time, in ticks
//   pwm        out  registered PWM output
//   period_end out  registered one-clk pulse after each period wrap

module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm,
  output logic             period_end
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             etick;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] per_sh;
  logic [WIDTH-1:0] duty_sh;
  logic [WIDTH-1:0] per_pd;
  logic [WIDTH-1:0] duty_pd;
  logic             pend;

  logic             wrap;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] per_nx;
  logic [WIDTH-1:0] duty_nx;
  logic [WIDTH-1:0] per_pd_nx;
  logic [WIDTH-1:0] duty_pd_nx;
  logic             pend_nx;

`ifdef PWM_TICK_SYNC_EN
  // tick_s1/tick_s2 form the synchronizer; tick_s3 holds the previous
  // synchronized level so a rising edge yields exactly one etick.
  logic tick_s1;
  logic tick_s2;
  logic tick_s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_s3 <= 1'b0;
    end else begin
      tick_s1 <= tick;
      tick_s2 <= tick_s1;
      tick_s3 <= tick_s2;
    end
  end

  assign etick = tick_s2 & ~tick_s3;
`else
  assign etick = tick;
`endif

  always_comb begin
    wrap       = en && etick && (cnt == per_sh);
    per_nx     = per_sh;
    duty_nx    = duty_sh;
    per_pd_nx  = per_pd;
    duty_pd_nx = duty_pd;
    pend_nx    = pend;

    if (!en) begin
      // Idle: pending values go live immediately; a load made while idle
      // lands in the pending registers and is applied on the following edge.
      if (pend) begin
        per_nx  = per_pd;
        duty_nx = duty_pd;
        pend_nx = 1'b0;
      end
      if (load) begin
        per_pd_nx  = period;
        duty_pd_nx = duty;
        pend_nx    = 1'b1;
      end
    end else if (wrap && load) begin
      // Load coinciding with the wrap bypasses the pending stage.
      per_nx  = period;
      duty_nx = duty;
      pend_nx = 1'b0;
    end else if (wrap && pend) begin
      per_nx  = per_pd;
      duty_nx = duty_pd;
      pend_nx = 1'b0;
    end else if (load) begin
      per_pd_nx  = period;
      duty_pd_nx = duty;
      pend_nx    = 1'b1;
    end

    cnt_nx = wrap ? '0 : cnt + ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      per_sh     <= '0;
      duty_sh    <= '0;
      per_pd     <= '0;
      duty_pd    <= '0;
      pend       <= 1'b0;
      pwm        <= 1'b0;
      period_end <= 1'b0;
    end else begin
      per_sh  <= per_nx;
      duty_sh <= duty_nx;
      per_pd  <= per_pd_nx;
      duty_pd <= duty_pd_nx;
      pend    <= pend_nx;

      if (!en) begin
        // Parking cnt at the (new) period end makes the first etick after
        // enable a wrap.
        cnt        <= per_nx;
        pwm        <= 1'b0;
        period_end <= 1'b0;
      end else begin
        if (etick) begin
          cnt <= cnt_nx;
          // duty_nx already carries the newly loaded duty at a reloading wrap.
          pwm <= (cnt_nx < duty_nx);
        end
        period_end <= wrap;
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
module tb_pwm_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       tick;
  logic       load;
  logic [7:0] period;
  logic [7:0] duty;
  logic       pwm;
  logic       period_end;

  int n_vec;
  int n_err;

  typedef struct {
    logic       en;
    logic       tick;
    logic       load;
    logic [7:0] period;
    logic [7:0] duty;
    logic       exp_pwm;
    logic       exp_pe;
  } vec_t;

  vec_t vq[$];

  pwm_gen #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .tick       (tick),
    .load       (load),
    .period     (period),
    .duty       (duty),
    .pwm        (pwm),
    .period_end (period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic t, input logic l, input logic [7:0] p,
                     input logic [7:0] d, input logic xp, input logic xe);
    vec_t v;
    v.en = e; v.tick = t; v.load = l; v.period = p; v.duty = d;
    v.exp_pwm = xp; v.exp_pe = xe;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = 1'b0; tick = 1'b0; load = 1'b0; period = '0; duty = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", 0, pwm, 1'b0);
    check("rst_pe", 0, period_end, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    do_reset();

`ifndef PWM_TICK_SYNC_EN
    // Steady period 4 / duty 2, loaded on the first (wrapping) tick.
    add(1,1,1,4,2, 1,1);
    add(1,1,0,4,2, 1,0);
    add(1,1,0,4,2, 0,0);
    add(1,1,0,4,2, 0,0);
    add(1,1,0,4,2, 0,0);
    add(1,1,0,4,2, 1,1);
    add(1,1,0,4,2, 1,0);
    add(1,1,0,4,2, 0,0);
    add(1,1,0,4,2, 0,0);
    add(1,1,0,4,2, 0,0);
    add(1,1,0,4,2, 1,1);
    // No tick: hold.
    add(1,0,0,4,2, 1,0);
    add(1,0,0,4,2, 1,0);
    add(1,1,0,4,2, 1,0);
    add(1,1,0,4,2, 0,0);
    // duty=0 loaded mid-period, effective at the wrap.
    add(1,1,1,4,0, 0,0);
    add(1,1,0,4,0, 0,0);
    add(1,1,0,4,0, 0,1);
    add(1,1,0,4,0, 0,0);
    add(1,1,0,4,0, 0,0);
    add(1,1,0,4,0, 0,0);
    add(1,1,0,4,0, 0,0);
    add(1,1,0,4,0, 0,1);
    // period=0, duty=1: every tick wraps.
    add(1,1,1,0,1, 0,0);
    add(1,1,0,0,1, 0,0);
    add(1,1,0,0,1, 0,0);
    add(1,1,0,0,1, 0,0);
    add(1,1,0,0,1, 1,1);
    add(1,1,0,0,1, 1,1);
    add(1,1,0,0,1, 1,1);
    add(1,0,0,0,1, 1,0);
    add(1,1,0,0,1, 1,1);
    // Load on the wrap edge: period 3 ticks, pwm 1,0,0.
    add(1,1,1,2,1, 1,1);
    add(1,1,0,2,1, 0,0);
    add(1,1,0,2,1, 0,0);
    add(1,1,0,2,1, 1,1);
    add(1,1,0,2,1, 0,0);
    // Disable, load while idle, re-enable.
    add(0,1,0,2,1, 0,0);
    add(0,1,1,3,3, 0,0);
    add(0,0,0,3,3, 0,0);
    add(1,0,0,3,3, 0,0);
    add(1,1,0,3,3, 1,1);
    add(1,1,0,3,3, 1,0);
    add(1,1,0,3,3, 1,0);
    add(1,1,0,3,3, 0,0);
    add(1,1,0,3,3, 1,1);

    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; tick = vq[i].tick; load = vq[i].load;
      period = vq[i].period; duty = vq[i].duty;
      step();
      check("tbl_pwm", i, pwm, vq[i].exp_pwm);
      check("tbl_pe", i, period_end, vq[i].exp_pe);
    end

    // Deferred update: period 9 duty 3, duty 7 loaded while cnt=5.
    do_reset();
    en = 1'b1; tick = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      load = (i == 0) || (i == 6);
      period = 8'd9;
      duty = (i == 0) ? 8'd3 : 8'd7;
      step();
      check("defer_pwm", i, pwm, (i < 10) ? ((i % 10) < 3) : ((i % 10) < 7));
      check("defer_pe", i, period_end, (i % 10) == 0);
    end
    load = 1'b0;

    // duty=200 with period=99: always high.
    do_reset();
    en = 1'b1; tick = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      load = (i == 0);
      period = 8'd99; duty = 8'd200;
      step();
      check("big_pwm", i, pwm, 1'b1);
      check("big_pe", i, period_end, (i % 100) == 0);
    end
    load = 1'b0;

    // Asynchronous reset at cnt=6, then restart from cleared shadows.
    do_reset();
    en = 1'b1; tick = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      load = (i == 0);
      period = 8'd9; duty = 8'd7;
      step();
    end
    load = 1'b0;
    check("pre_rst_pwm", 0, pwm, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pwm", 0, pwm, 1'b0);
    check("async_rst_pe", 0, period_end, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    check("post_rst_pwm", 0, pwm, 1'b0);
    check("post_rst_pe", 0, period_end, 1'b1);
    step();
    check("post_rst_pe2", 0, period_end, 1'b1);
`else
    // Divide-by-6 level tick: one etick per 6 clk, pulse 3 edges after rise.
    en = 1'b1;
    for (int n = 0; n < 48; n++) begin
      tick = ((n % 6) < 3);
      step();
      check("sync_pe", n, period_end, (n % 6) == 2);
      check("sync_pwm", n, pwm, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
